// File: rtl/fetch_unit.sv
// Instruction-fetch front end: fetch PC, req/ack memory handshake, DEPTH-entry instr/PC queue.
// Optional build macro FETCH_HLT_DETECT_EN: halt fetch after a pushed HLT instruction.
module fetch_unit #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  parameter logic [ADDR_W-1:0] INIT_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               out_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(INSTR_W / 8);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_DRAIN, S_HALT} state_t;

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  pc_reg, pc_next;
  logic [ADDR_W-1:0]  req_addr_reg, req_addr_next;
  logic               halt_reg;
  logic               halted_reg;
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];

  logic req_c, push, pop, flush, halt_block, hlt_match, not_full;

`ifdef FETCH_HLT_DETECT_EN
  localparam logic [INSTR_W-1:0] HLT_MASK = INSTR_W'(32'hFFE0001F);
  localparam logic [INSTR_W-1:0] HLT_PAT  = INSTR_W'(32'hD4400000);
  assign hlt_match = ((imem_rdata & HLT_MASK) == HLT_PAT);
`else
  assign hlt_match = 1'b0;
`endif

  // The halt input blocks a new request in the very cycle it is raised.
  assign halt_block = halt_reg | halt;
  assign not_full   = (count_reg < CNT_W'(DEPTH));

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    req_addr_next = req_addr_reg;
    req_c         = 1'b0;
    push          = 1'b0;
    flush         = 1'b0;
    case (state_reg)
      S_RUN: begin
        req_c = !halt_block && not_full;
        if (redirect) begin
          flush   = 1'b1;
          pc_next = redirect_pc;
        end else if (req_c) begin
          req_addr_next = pc_reg;
          if (imem_ack) begin
            push    = 1'b1;
            pc_next = pc_reg + PC_INC;
          end else begin
            state_next = S_WAIT;
          end
        end else if (halt_block) begin
          state_next = S_HALT;
        end
      end
      S_WAIT: begin
        req_c = 1'b1;
        if (redirect) begin
          flush      = 1'b1;
          pc_next    = redirect_pc;
          state_next = imem_ack ? S_RUN : S_DRAIN;
        end else if (imem_ack) begin
          push       = 1'b1;
          pc_next    = pc_reg + PC_INC;
          state_next = (halt_block || hlt_match) ? S_HALT : S_RUN;
        end
      end
      S_DRAIN: begin
        req_c = 1'b1;
        if (redirect) begin
          flush   = 1'b1;
          pc_next = redirect_pc;
        end
        if (imem_ack) begin
          state_next = halt_block ? S_HALT : S_RUN;
        end
      end
      default: ;
    endcase
  end

  assign pop = (count_reg != '0) && out_ready && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_RUN;
      pc_reg       <= INIT_PC;
      req_addr_reg <= INIT_PC;
      halt_reg     <= 1'b0;
      halted_reg   <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      req_addr_reg <= req_addr_next;
      halt_reg     <= halt_reg | halt | (push & hlt_match);
      halted_reg   <= (state_reg == S_HALT);
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Storage is not reset; out_* are masked to zero while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_reg] <= imem_rdata;
      pc_mem[wr_ptr_reg]    <= imem_addr;
    end
  end

  assign imem_req  = req_c & ~reset;
  assign imem_addr = (state_reg == S_RUN) ? pc_reg : req_addr_reg;
  assign out_valid = (count_reg != '0);
  assign out_instr = out_valid ? instr_mem[rd_ptr_reg] : '0;
  assign out_pc    = out_valid ? pc_mem[rd_ptr_reg] : '0;
  assign pc        = pc_reg;
  assign halted    = halted_reg;

endmodule
